reg_bus_master: RTL and testbench

//  Initiator for the 2-bit-address register bus served by the axiSlave register block.
//  - Accepts one read or write command at a time from local control logic over a valid/ready pair.
//  - Drives the bus, waits for writeResponse or a fixed read latency, then returns data/status over a valid/ready pair.
//  - Write completion is bounded by a timeout counter.

---
 rtl/reg_bus_pkg.sv | 14 +
 rtl/reg_bus_master.sv | 113 +++++++++++
 tb/tb_reg_bus_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the 2-bit-address register bus and its initiator.
package reg_bus_pkg;

    localparam int BUS_ADDR_WIDTH = 2;
    localparam int BUS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

endpackage

// File: rtl/reg_bus_master.sv
// Register bus initiator: takes one command at a time, drives the bus, and
// returns read data or write status, with writes bounded by a timeout.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int DATA_WIDTH   = BUS_DATA_WIDTH,
    parameter int ADDR_WIDTH   = BUS_ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic                  cmdWrite,
    input  logic [ADDR_WIDTH-1:0] cmdAddr,
    input  logic [DATA_WIDTH-1:0] cmdData,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [DATA_WIDTH-1:0] rspData,
    output logic                  rspErr,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeResponse,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [DATA_WIDTH-1:0] readData
);

    localparam int TIMER_MAX   = (TIMEOUT > READ_LATENCY + 1) ? TIMEOUT : READ_LATENCY + 1;
    localparam int TIMER_WIDTH = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_WIDTH-1:0] WRITE_LAST = TIMER_WIDTH'(TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] READ_LAST  = TIMER_WIDTH'(READ_LATENCY);

    state_t                 state;
    logic [TIMER_WIDTH-1:0] timer;

    // NOTE: every state bit and output is a register updated with <=, so all of
    // them see pre-edge values and no ordering hazards arise inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            cmdReady     <= 1'b0;
            rspValid     <= 1'b0;
            rspData      <= '0;
            rspErr       <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
            readAddress  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid && cmdReady) begin
                        cmdReady <= 1'b0;
                        timer    <= '0;
                        if (cmdWrite) begin
                            writeAddress <= cmdAddr;
                            writeData    <= cmdData;
                            state        <= WRITE;
                        end else begin
                            readAddress <= cmdAddr;
                            state       <= READ;
                        end
                    end else begin
                        cmdReady <= 1'b1;
                    end
                end

                // An acknowledge on the final allowed cycle still counts as success.
                WRITE: begin
                    if (writeResponse) begin
                        rspData  <= '0;
                        rspErr   <= 1'b0;
                        rspValid <= 1'b1;
                        state    <= RESP;
                    end else if (timer == WRITE_LAST) begin
                        rspData  <= '0;
                        rspErr   <= 1'b1;
                        rspValid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                READ: begin
                    if (timer == READ_LAST) begin
                        rspData  <= readData;
                        rspErr   <= 1'b0;
                        rspValid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        cmdReady <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Randomized bench for reg_bus_master against a transaction-level model of
// the register bus, its slave and the expected response timing.
module tb_reg_bus_master;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int RL = 1;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmdValid;
    logic          cmdReady;
    logic          cmdWrite;
    logic [AW-1:0] cmdAddr;
    logic [DW-1:0] cmdData;
    logic          rspValid;
    logic          rspReady;
    logic [DW-1:0] rspData;
    logic          rspErr;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeData;
    logic          writeResponse;
    logic [AW-1:0] readAddress;
    logic [DW-1:0] readData;

    always #5 clk = ~clk;

    reg_bus_master #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmdValid     (cmdValid),
        .cmdReady     (cmdReady),
        .cmdWrite     (cmdWrite),
        .cmdAddr      (cmdAddr),
        .cmdData      (cmdData),
        .rspValid     (rspValid),
        .rspReady     (rspReady),
        .rspData      (rspData),
        .rspErr       (rspErr),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .writeResponse(writeResponse),
        .readAddress  (readAddress),
        .readData     (readData)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Register contents as the model believes them vs. what the bus slave stores.
    logic [DW-1:0] model_mem [4];
    logic [DW-1:0] slave_mem [4];
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    logic [AW-1:0] exp_raddr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_bus(input string tag);
        check({tag, "_waddr"}, 64'(writeAddress), 64'(exp_waddr));
        check({tag, "_wdata"}, 64'(writeData), 64'(exp_wdata));
        check({tag, "_raddr"}, 64'(readAddress), 64'(exp_raddr));
    endtask

    task automatic scramble_cmd();
        cmdValid = 1'($urandom);
        cmdWrite = 1'($urandom);
        cmdAddr  = AW'($urandom);
        cmdData  = $urandom;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && cmdReady !== 1'b1; i++) @(negedge clk);
        check("cmd_ready_wait", 64'(cmdReady), 64'd1);
    endtask

    // ack_cycle: WRITE cycle (1-based) in which the slave acknowledges; 0 = never.
    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int ack_cycle, input int stall);
        int            exp_cyc;
        bit            exp_err;
        logic [DW-1:0] exp_data;

        wait_ready();
        cmdValid = 1'b1;
        cmdWrite = wr;
        cmdAddr  = addr;
        cmdData  = data;

        if (wr) begin
            exp_waddr = addr;
            exp_wdata = data;
            exp_data  = '0;
            if (ack_cycle >= 1 && ack_cycle <= TO) begin
                exp_cyc         = ack_cycle + 1;
                exp_err         = 1'b0;
                model_mem[addr] = data;
            end else begin
                exp_cyc = TO + 1;
                exp_err = 1'b1;
            end
        end else begin
            exp_raddr = addr;
            exp_cyc   = RL + 2;
            exp_err   = 1'b0;
            exp_data  = model_mem[addr];
        end

        for (int cyc = 1; cyc <= exp_cyc; cyc++) begin
            @(negedge clk);
            scramble_cmd();
            check_bus("busy");
            check("busy_cmd_ready", 64'(cmdReady), 64'd0);
            check("rsp_valid_timing", 64'(rspValid), 64'(cyc == exp_cyc));
            if (cyc < exp_cyc) begin
                rspReady      = 1'($urandom);
                writeResponse = wr && (cyc == ack_cycle);
                if (writeResponse) slave_mem[writeAddress] = writeData;
                readData = (!wr && cyc == RL + 1) ? slave_mem[readAddress] : $urandom;
            end else begin
                rspReady      = 1'b0;
                writeResponse = 1'b0;
                readData      = $urandom;
                check("rsp_data", 64'(rspData), 64'(exp_data));
                check("rsp_err", 64'(rspErr), 64'(exp_err));
            end
        end

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            scramble_cmd();
            check("stall_valid", 64'(rspValid), 64'd1);
            check("stall_data", 64'(rspData), 64'(exp_data));
            check("stall_err", 64'(rspErr), 64'(exp_err));
            check("stall_cmd_ready", 64'(cmdReady), 64'd0);
            check_bus("stall");
        end

        rspReady = 1'b1;
        cmdValid = 1'b0;
        @(negedge clk);
        rspReady = 1'b0;
        check("post_rsp_valid", 64'(rspValid), 64'd0);
        check("post_cmd_ready", 64'(cmdReady), 64'd1);
        check_bus("post");
    endtask

    initial begin
        rst           = 1'b1;
        cmdValid      = 1'b0;
        cmdWrite      = 1'b0;
        cmdAddr       = '0;
        cmdData       = '0;
        rspReady      = 1'b0;
        writeResponse = 1'b0;
        readData      = '0;
        exp_waddr     = '0;
        exp_wdata     = '0;
        exp_raddr     = '0;
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = '0;
            slave_mem[i] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmdReady), 64'd0);
        check("rst_rsp_valid", 64'(rspValid), 64'd0);
        check("rst_rsp_err", 64'(rspErr), 64'd0);
        check("rst_rsp_data", 64'(rspData), 64'd0);
        check_bus("rst");
        rst = 1'b0;
        @(negedge clk);
        check("out_of_rst_cmd_ready", 64'(cmdReady), 64'd1);

        // Directed scenarios
        run_cmd(1'b1, 2'd1, 32'hDEADBEEF, 2, 0);
        run_cmd(1'b1, 2'd2, 32'h12345678, 1, 0);
        run_cmd(1'b0, 2'd2, '0, 0, 0);
        run_cmd(1'b1, 2'd3, 32'hCAFEF00D, 0, 1);
        run_cmd(1'b0, 2'd1, '0, 0, 5);
        run_cmd(1'b1, 2'd0, 32'hA5A5A5A5, TO, 0);
        run_cmd(1'b1, 2'd3, 32'h0BADC0DE, TO - 1, 0);
        run_cmd(1'b1, 2'd0, 32'h55AA55AA, TO + 1, 2);
        run_cmd(1'b0, 2'd0, '0, 0, 0);
        run_cmd(1'b0, 2'd3, '0, 0, 0);

        // Reset during the third WRITE cycle aborts the command silently.
        wait_ready();
        cmdValid = 1'b1;
        cmdWrite = 1'b1;
        cmdAddr  = 2'd2;
        cmdData  = 32'hFFFF0000;
        repeat (3) begin
            @(negedge clk);
            cmdValid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_raddr = '0;
        check("abort_cmd_ready", 64'(cmdReady), 64'd0);
        check("abort_rsp_valid", 64'(rspValid), 64'd0);
        check("abort_rsp_err", 64'(rspErr), 64'd0);
        check("abort_rsp_data", 64'(rspData), 64'd0);
        check_bus("abort");
        for (int i = 0; i < TO + 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(rspValid), 64'd0);
        end
        run_cmd(1'b0, 2'd2, '0, 0, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            run_cmd(1'($urandom), AW'($urandom), $urandom,
                    int'($urandom_range(TO + 2, 0)), int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
